regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-port register-file write arbiter with one-entry slots, round-robin
// between distinct registers and age ordering for same-register writes.
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [3:0]  req0_reg,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_reg,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  output logic [15:0] pending_mask
);

  logic        v0_q, v1_q, v0_d, v1_d;
  logic [3:0]  r0_q, r1_q;
  logic [15:0] d0_q, d1_q;
  logic        last_q, last_d;
  logic        order_q, order_d;
  logic        we_q;
  logic [3:0]  dreg_q;
  logic [15:0] ddata_q;
  logic        g0, g1, ld0, ld1;
  logic [3:0]  greg;
  logic [15:0] gdata;
  logic [15:0] mask;

  // order_q=1 means slot 1 holds the older write
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (1'b1)
      (v0_q & v1_q): begin
        g1 = (r0_q == r1_q) ? order_q : ~last_q;
        g0 = ~g1;
      end
      (v0_q & ~v1_q): g0 = 1'b1;
      (~v0_q & v1_q): g1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = ~v0_q | g0;
  assign req1_ready = ~v1_q | g1;
  assign ld0 = req0_valid & req0_ready;
  assign ld1 = req1_valid & req1_ready;

  assign v0_d = ld0 | (v0_q & ~g0);
  assign v1_d = ld1 | (v1_q & ~g1);
  assign greg  = g1 ? r1_q : r0_q;
  assign gdata = g1 ? d1_q : d0_q;

  always_comb begin
    last_d = last_q;
    if (g1) last_d = 1'b1;
    else if (g0) last_d = 1'b0;
  end

  always_comb begin
    order_d = order_q;
    if (ld0 & ld1) order_d = 1'b0;
    else if (ld0 & v1_q & ~g1) order_d = 1'b1;
    else if (ld1 & v0_q & ~g0) order_d = 1'b0;
  end

  always_comb begin
    mask = 16'h0000;
    if (v0_q) mask[r0_q] = 1'b1;
    if (v1_q) mask[r1_q] = 1'b1;
    mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      r0_q    <= 4'h0;
      r1_q    <= 4'h0;
      d0_q    <= 16'h0000;
      d1_q    <= 16'h0000;
      last_q  <= 1'b1;
      order_q <= 1'b0;
      we_q    <= 1'b0;
      dreg_q  <= 4'h0;
      ddata_q <= 16'h0000;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      last_q  <= last_d;
      order_q <= order_d;
      if (ld0) begin
        r0_q <= req0_reg;
        d0_q <= req0_data;
      end
      if (ld1) begin
        r1_q <= req1_reg;
        d1_q <= req1_data;
      end
      we_q <= (g0 | g1) & (greg != 4'h0);
      if (g0 | g1) begin
        dreg_q  <= greg;
        ddata_q <= gdata;
      end
    end
  end

  assign WriteReg     = we_q;
  assign DstReg       = dreg_q;
  assign DstData      = ddata_q;
  assign pending_mask = mask;

endmodule
